// File: rtl/nfa_pkg.sv
// nfa_pkg: shared types, configuration selectors and attribute helpers for the NFA engine
package nfa_pkg;
    typedef enum logic [1:0] {
        START_NONE = 2'd0,
        START_SOD  = 2'd1,
        START_ALL  = 2'd2
    } start_type_e;

    localparam logic [1:0] CFG_MATCH = 2'd0;
    localparam logic [1:0] CFG_EDGE  = 2'd1;
    localparam logic [1:0] CFG_ATTR  = 2'd2;

    localparam int ATTR_ST_LO = 0;
    localparam int ATTR_ST_HI = 1;
    localparam int ATTR_REP   = 2;

    function automatic logic [2:0] attr_word(input start_type_e st, input logic rep);
        return {rep, st};
    endfunction

    function automatic logic start_en(input logic [1:0] st, input logic sod);
        return (st == START_ALL) | ((st == START_SOD) & sod);
    endfunction
endpackage

// File: rtl/nfa_report_fifo.sv
// nfa_report_fifo: report event queue with full-drop, sticky overflow and zeroed empty head
module nfa_report_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] head,
    output logic         overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          full, pop, accept;

    assign valid  = count != '0;
    assign full   = count == (AW+1)'(DEPTH);
    assign pop    = valid & ready;
    // a pop in the same cycle frees the slot, so a push on full is still taken
    assign accept = push & (~full | pop);
    assign head   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset | clear) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(accept) - (AW+1)'(pop);
            if (push & ~accept) overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/nfa_prog_engine.sv
// nfa_prog_engine: runtime-programmable homogeneous NFA with symbol-indexed report FIFO
module nfa_prog_engine
    import nfa_pkg::*;
#(
    parameter int NUM_STE      = 16,
    parameter int SYM_W        = 8,
    parameter int COUNT_W      = 32,
    parameter int REPORT_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic [SYM_W-1:0]           symbols,
    input  logic                       flush,
    input  logic                       cfg_we,
    input  logic [1:0]                 cfg_sel,
    input  logic [$clog2(NUM_STE)-1:0] cfg_ste,
    input  logic [SYM_W-1:0]           cfg_sym,
    input  logic [NUM_STE-1:0]         cfg_wdata,
    output logic                       cfg_err,
    output logic [NUM_STE-1:0]         active,
    output logic                       report_valid,
    input  logic                       report_ready,
    output logic [NUM_STE-1:0]         report_vec,
    output logic [COUNT_W-1:0]         report_idx,
    output logic                       report_overflow
);
    localparam int STE_W = $clog2(NUM_STE);

    logic [NUM_STE-1:0] bitmap [2**SYM_W];
    logic [NUM_STE-1:0] edge_mask [NUM_STE];
    logic [1:0]         start_type [NUM_STE];
    logic [NUM_STE-1:0] report_en, en, next_active, hits;
    logic [COUNT_W-1:0] idx;
    logic               sod, cfg_ok, step;
    logic [2**STE_W-1:0] ste_ok;
    logic [NUM_STE+2:0] wd;
    logic [NUM_STE+COUNT_W-1:0] head;

    // STE indices past NUM_STE are representable on cfg_ste but must be rejected
    for (genvar k = 0; k < 2**STE_W; k++) begin : g_ok
        assign ste_ok[k] = k < NUM_STE;
    end

    assign wd     = {3'b0, cfg_wdata};
    assign cfg_ok = cfg_we & ~run & ste_ok[cfg_ste] & (cfg_sel != 2'd3);
    assign step   = run & ~flush;

    always_comb begin
        en = '0;
        for (int i = 0; i < NUM_STE; i++)
            en[i] = |(active & edge_mask[i]) | start_en(start_type[i], sod);
    end

    assign next_active = en & bitmap[symbols];
    assign hits        = next_active & report_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 2**SYM_W; s++) bitmap[s] <= '0;
            for (int i = 0; i < NUM_STE; i++) begin
                edge_mask[i]  <= '0;
                start_type[i] <= START_NONE;
            end
            report_en <= '0;
            active    <= '0;
            idx       <= '0;
            sod       <= 1'b1;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_we & ~cfg_ok;
            if (cfg_ok) begin
                if (cfg_sel == CFG_MATCH) bitmap[cfg_sym][cfg_ste] <= wd[0];
                if (cfg_sel == CFG_EDGE) edge_mask[cfg_ste] <= cfg_wdata;
                if (cfg_sel == CFG_ATTR) begin
                    start_type[cfg_ste] <= wd[ATTR_ST_HI:ATTR_ST_LO];
                    report_en[cfg_ste]  <= wd[ATTR_REP];
                end
            end
            if (flush) begin
                active <= '0;
                idx    <= '0;
                sod    <= 1'b1;
            end else if (run) begin
                active <= next_active;
                idx    <= idx + COUNT_W'(1);
                sod    <= 1'b0;
            end
        end
    end

    nfa_report_fifo #(.W(NUM_STE + COUNT_W), .DEPTH(REPORT_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (step & |hits),
        .push_data ({hits, idx}),
        .ready     (report_ready),
        .valid     (report_valid),
        .head      (head),
        .overflow  (report_overflow)
    );

    assign {report_vec, report_idx} = head;
endmodule

// File: doc/nfa_prog_engine.md
Name: nfa_prog_engine

Overview:
- Runtime-programmable, homogeneous NFA engine. Successor to the fixed, generator-emitted automata in the monitor clusters.
- NUM_STE state-transition elements, each with:
  - a programmable symbol-class bitmap,
  - a programmable incoming-edge mask,
  - a start type and a report enable.
- Consumes one SYM_W-bit symbol per run cycle.
- Queues report events, each carrying the symbol index, into a handshaked FIFO for the monitor aggregation logic.

Parameters:
- NUM_STE, 16: number of STEs (2..64).
- SYM_W, 8: symbol width; each bitmap has 2**SYM_W entries.
- COUNT_W, 32: width of the symbol-index counter.
- REPORT_DEPTH, 4: report FIFO depth; power of 2, minimum 2.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- run, in, 1: symbol valid; the engine advances only when run=1.
- symbols, in, SYM_W: current symbol.
- flush, in, 1: restart the stream, clearing dynamic state.
- cfg_we, in, 1: configuration write strobe.
- cfg_sel, in, 2: write target. 0 = match bit, 1 = edge mask, 2 = attributes.
- cfg_ste, in, clog2(NUM_STE): target STE.
- cfg_sym, in, SYM_W: bitmap address (used when cfg_sel=0).
- cfg_wdata, in, NUM_STE: write data.
  - sel 0: bit0 = match bit.
  - sel 1: source mask.
  - sel 2: [1:0] start type, [2] report enable.
- cfg_err, out, 1: one-cycle pulse on a rejected configuration write.
- active, out, NUM_STE: current active-state vector.
- report_valid, out, 1: FIFO head is valid.
- report_ready, in, 1: consumer accepts the FIFO head.
- report_vec, out, NUM_STE: reporting STEs of the head entry.
- report_idx, out, COUNT_W: symbol index of the head entry.
- report_overflow, out, 1: sticky flag, set when a report event is dropped.

Behaviour:
- Reset values:
  - All configuration storage is 0, so no STE has match bits, edges or start type.
  - active=0, symbol index=0, FIFO empty, report_valid=0, report_overflow=0, cfg_err=0.
  - start-of-data is armed.
- Start types: 0 = none, 1 = start-of-data (enabled only on the first run cycle after reset or flush), 2 = all-input (enabled every run cycle), 3 = reserved and treated as 0.
- Run cycle (run=1, flush=0):
  - en[i] = |(active & edge_mask[i]) | start term.
  - active[i] <= en[i] & bitmap[i][symbols].
  - Symbol index increments by 1 and wraps modulo 2**COUNT_W. Start-of-data disarms.
  - Latency: a symbol at cycle t is reflected in active at t+1.
- Report path:
  - hits = next_active & report_en.
  - If hits != 0, push {hits, index of the current symbol} in the same cycle that active updates.
  - The entry is visible on report_valid at t+1 if the FIFO was empty.
  - The first symbol after reset or flush has index 0.
- run=0: active, index and start-of-data state hold. Pops still operate.
- FIFO:
  - A pop occurs when report_valid & report_ready.
  - Push on full without a same-cycle pop: the event is dropped and report_overflow is set.
  - Push on full with a same-cycle pop: the push is accepted and no overflow is flagged.
  - Outputs are driven from the head register; report_vec and report_idx are 0 when empty.
- flush:
  - Clears active, the index, the FIFO and report_overflow, and re-arms start-of-data.
  - Has priority over run; the symbol in a flush cycle is discarded and not counted.
  - Configuration is retained.
- Configuration:
  - Writes are accepted only when run=0 and take effect on the next cycle.
  - cfg_we with run=1, cfg_ste >= NUM_STE, or cfg_sel=3 is ignored and pulses cfg_err for one cycle.
- reset mid-stream: identical to the reset values above, including clearing configuration.
- Self-loops are allowed (edge_mask[i][i]). Fan-in is unrestricted, up to NUM_STE.

Decomposition:
- Shared package nfa_pkg holds:
  - start_type_e enum (START_NONE, START_SOD, START_ALL),
  - cfg_sel constants (CFG_MATCH, CFG_EDGE, CFG_ATTR),
  - a helper for the attribute bit positions.
- One sub-module: nfa_report_fifo, parametrised by width and depth, with the push, pop, full-drop and overflow logic.
- The STE array, bitmaps and counter stay in the top module.

Test Plan:
- Chain SOD→B→C on symbols 0x41, 0x42, 0x43; C has report enable. Stream 41,42,43 → active one-hot progresses on cycles t+1..t+3; one report with vec=C and idx=2.
- Same chain, stream 41,00,42,43 → no report. Then flush and stream 41,42,43 → report with idx=2 (index restarted).
- START_ALL STE with all bitmap bits set and report enable, REPORT_DEPTH=4, report_ready=0, 6 symbols → 4 entries with idx 0..3 retained; report_overflow=1. Then drain → idx 0,1,2,3 in order, and report_overflow stays 1 until flush.
- FIFO full with report_ready=1 and a push in the same cycle → push accepted, report_overflow stays 0.
- cfg_we while run=1 → cfg_err=1 for one cycle and configuration unchanged. cfg_ste=NUM_STE with run=0 → cfg_err pulses.
- Reset asserted mid-stream with active≠0 and the FIFO non-empty → next cycle: active=0, report_valid=0, all bitmaps read back as no-match, so symbols produce no activity.
